vector_sequencer: RTL and testbench
===================================

Name: vector_sequencer

Overview:
- Synthesizable stimulus/response engine for small combinational DUTs.
- Walks every input combination onto the DUT's inputs, waits a settle interval, then samples the DUT's single output.
- Compares each sample against a parameterised truth table and reports pass/fail, a mismatch count and the first failing vector.
- Sits beside the combinational block in hardware self-test and FPGA bring-up builds.

Parameters:
- N_IN, 3, number of DUT inputs; vectors run 0 .. 2^N_IN-1, MSB drives the first DUT input (A).
- SETTLE, 2, cycles each vector is held before sampling; legal range >=1.
- EXPECTED, 8'b1110_1000, truth table of width 2^N_IN; bit i is the expected output for vector i. The default is 3-input majority, so vector 3'b010 expects 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begins a run; sampled only in IDLE or DONE
- dut_in  out  N_IN  current vector driven to the DUT
- dut_out  in  1  DUT response
- busy  out  1  run in progress
- done  out  1  run complete; held until next start
- pass  out  1  done and zero mismatches
- fail_count  out  N_IN+1  number of mismatching vectors
- first_fail_vec  out  N_IN  lowest-index failing vector
- first_fail_valid  out  1  first_fail_vec is meaningful

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE
  - dut_in=0, busy=0, done=0, pass=0
  - fail_count=0, first_fail_vec=0, first_fail_valid=0
  - settle counter=0
- All outputs are registered.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE with start=1:
  - next state DRIVE; vec=0 (dut_in=0), busy=1.
  - done, pass, fail_count, first_fail_* are cleared.
- DRIVE:
  - holds dut_in for SETTLE cycles; settle counter runs 0..SETTLE-1.
  - when counter reaches SETTLE-1, go to SAMPLE.
- SAMPLE (1 cycle):
  - compare dut_out with EXPECTED[vec].
  - on mismatch: fail_count += 1; if first_fail_valid=0, set first_fail_vec=vec and first_fail_valid=1.
  - if vec < 2^N_IN-1: vec+1, counter=0, back to DRIVE.
  - else: go to DONE.
- DONE:
  - busy=0, done=1.
  - pass=1 iff final fail_count==0; pass is registered on DONE entry and uses the count including the last SAMPLE.
  - dut_in keeps the last vector.
  - start=1 restarts exactly as from IDLE, with the same clearing.
- Timing:
  - run length from the start-accepting edge to done=1 is 2^N_IN*(SETTLE+1) cycles; 24 cycles with defaults.
  - dut_out is sampled SETTLE cycles after dut_in changes.
- start while busy (DRIVE/SAMPLE) is ignored, with no effect on progress or results.
- start held continuously: starts once; in DONE it restarts on the following edge.
- Width rules:
  - fail_count is N_IN+1 bits, so 2^N_IN mismatches fit without wrap.
  - vec is N_IN bits and never wraps, because DONE is entered before any increment past 2^N_IN-1.
- Reset mid-run: immediate return to reset values; no partial results are retained.

Decomposition:
- Package vector_sequencer_pkg holds:
  - the state enum (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - the function num_vectors(N_IN) = 2^N_IN;
  - the default majority truth table constant.
- One sub-module: settle_timer, a SETTLE-cycle down/up counter with clear and an expire pulse, instantiated once.
- Compare/count logic stays in the top module.

Test Plan:
- Majority DUT model, defaults, start pulse at cycle 5:
  - dut_in steps 000..111, each held 3 cycles.
  - done=1 and pass=1 exactly 24 cycles after start.
  - fail_count=0, first_fail_valid=0.
- DUT tied to 0:
  - fail_count=4, first_fail_vec=3'b011, first_fail_valid=1, pass=0, done=1.
- Inverted-majority DUT:
  - fail_count=8 (no wrap), first_fail_vec=3'b000, pass=0.
- Reset during the run:
  - rst_n low at cycle 10 after start: next sample shows all outputs 0 and dut_in=000, asynchronously.
  - start after release gives a full 24-cycle run with the correct result.
- start pulses during busy at cycles 3 and 12 after start:
  - no effect; done still at cycle 24.
  - start in DONE clears done/pass/fail_count the next cycle and reruns identically.
- SETTLE=1 override with majority DUT:
  - each vector held 2 cycles; done after 16 cycles; pass=1.

Source files
------------

// File: rtl/vector_sequencer_pkg.sv
// ============================================================================
//  Module      : vector_sequencer_pkg
//  Description : Shared types and constants for the vector sequencer: the
//                run-state encoding, the vector-count helper and the default
//                3-input majority truth table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vector_sequencer_pkg;

    // Run-state encoding; values are fixed so debug taps read consistently.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of distinct input vectors for an n-input DUT.
    function automatic int num_vectors(input int n);
        return 1 << n;
    endfunction

    // 3-input majority: bit i is the expected output for input vector i.
    localparam logic [7:0] MAJORITY_TT = 8'b1110_1000;

endpackage

`default_nettype wire

// File: rtl/vector_sequencer_settle.sv
// ============================================================================
//  Module      : settle_timer
//  Description : Counts 0..SETTLE-1 while enabled and raises expire during
//                the final count; clear forces the count back to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // SETTLE=1 still needs a one-bit counter that simply sits at zero.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [CW-1:0] count;

    // Expire is flagged on the last held cycle so the caller can move on.
    assign expire = enable && (count == LAST);

    // Settle counter: cleared outside the hold window, wraps to 0 on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= expire ? '0 : count + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/vector_sequencer.sv
// ============================================================================
//  Module      : vector_sequencer
//  Description : Exhaustive stimulus/response checker for a small
//                combinational block. Steps every input vector, holds it for
//                SETTLE cycles, samples the response and compares it with a
//                truth table, keeping a mismatch count and the first failure.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int                        N_IN     = 3,
    parameter int                        SETTLE   = 2,
    parameter logic [(1 << N_IN)-1:0]    EXPECTED = MAJORITY_TT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int              NV       = num_vectors(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

    state_t        state;
    logic          expire;
    logic          mismatch;
    logic [N_IN:0] fail_inc;

    // The timer only runs while a vector is being held; elsewhere it is
    // parked at zero so every DRIVE phase starts from a clean count.
    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != DRIVE),
        .enable (state == DRIVE),
        .expire (expire)
    );

    // Response check against the truth table entry for the current vector.
    always_comb begin
        mismatch = (dut_out != EXPECTED[dut_in]);
        fail_inc = fail_count + {{N_IN{1'b0}}, 1'b1};
    end

    // Sequencer FSM with registered outputs and result bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                // IDLE and DONE both accept start and wipe previous results.
                IDLE, DONE: begin
                    if (start) begin
                        state            <= DRIVE;
                        dut_in           <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        fail_count       <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        fail_count <= fail_inc;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= dut_in;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    // Stop on the last vector before incrementing, so the
                    // vector register never wraps.
                    if (dut_in != LAST_VEC) begin
                        dut_in <= dut_in + N_IN'(1);
                        state  <= DRIVE;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // The final sample's result is not in fail_count yet.
                        pass  <= (fail_count == '0) && !mismatch;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vector_sequencer.sv
// ============================================================================
//  Module      : tb_vector_sequencer
//  Description : Directed bench for vector_sequencer with several DUT models
//                (majority, stuck-at-0, inverted majority, stuck-at-1) and a
//                SETTLE=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start1;
    logic [2:0] dut_in,  dut_in1;
    logic       dut_out, dut_out1;
    logic       busy,  done,  pass,  ffv_valid;
    logic       busy1, done1, pass1, ffv_valid1;
    logic [3:0] fail_count, fail_count1;
    logic [2:0] ffv, ffv1;

    // 0 = majority, 1 = stuck at 0, 2 = inverted majority, 3 = stuck at 1
    int mode;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0:       dut_out = maj(dut_in);
            1:       dut_out = 1'b0;
            2:       dut_out = ~maj(dut_in);
            default: dut_out = 1'b1;
        endcase
    end

    assign dut_out1 = maj(dut_in1);

    vector_sequencer u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .dut_in           (dut_in),
        .dut_out          (dut_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_count       (fail_count),
        .first_fail_vec   (ffv),
        .first_fail_valid (ffv_valid)
    );

    vector_sequencer #(.SETTLE(1)) u_dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start1),
        .dut_in           (dut_in1),
        .dut_out          (dut_out1),
        .busy             (busy1),
        .done             (done1),
        .pass             (pass1),
        .fail_count       (fail_count1),
        .first_fail_vec   (ffv1),
        .first_fail_valid (ffv_valid1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulses start on the main instance, checks the clear on the accepting
    // edge, then follows the run cycle by cycle until done (bounded).
    task automatic run_main(input bit poke_busy, output int cycles, output int seq_err);
        int exp_vec;
        seq_err = 0;
        cycles  = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_clear_busy",  busy,       1);
        chk("start_clear_done",  done,       0);
        chk("start_clear_pass",  pass,       0);
        chk("start_clear_count", fail_count, 0);
        chk("start_clear_ffv",   {ffv_valid, ffv}, 0);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            exp_vec = (k / 3 > 7) ? 7 : k / 3;
            if (dut_in !== 3'(exp_vec)) seq_err++;
            if (done === 1'b1) begin
                if (busy !== 1'b0) seq_err++;
                cycles = k;
                break;
            end
            if (busy !== 1'b1) seq_err++;
            start = poke_busy && (k == 3 || k == 12);
        end
        start = 1'b0;
    endtask

    typedef struct {
        int         mode;
        logic [3:0] fcount;
        logic [2:0] ffvec;
        logic       ffvalid;
        logic       pass;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int   cyc;
        int   serr;

        tbl[0] = '{mode: 1, fcount: 4'd4, ffvec: 3'b011, ffvalid: 1'b1, pass: 1'b0};
        tbl[1] = '{mode: 0, fcount: 4'd0, ffvec: 3'b000, ffvalid: 1'b0, pass: 1'b1};
        tbl[2] = '{mode: 2, fcount: 4'd8, ffvec: 3'b000, ffvalid: 1'b1, pass: 1'b0};
        tbl[3] = '{mode: 3, fcount: 4'd4, ffvec: 3'b000, ffvalid: 1'b1, pass: 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {dut_in, busy, done, pass, fail_count, ffv, ffv_valid}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven runs with different DUT behaviours
        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_main(1'b0, cyc, serr);
            chk($sformatf("run%0d_cycles", i),  cyc,  24);
            chk($sformatf("run%0d_seq", i),     serr, 0);
            chk($sformatf("run%0d_count", i),   fail_count, tbl[i].fcount);
            chk($sformatf("run%0d_ffvalid", i), ffv_valid,  tbl[i].ffvalid);
            if (tbl[i].ffvalid)
                chk($sformatf("run%0d_ffvec", i), ffv, tbl[i].ffvec);
            chk($sformatf("run%0d_pass", i), pass, tbl[i].pass);
            chk($sformatf("run%0d_done", i), done, 1);
            repeat (2) @(negedge clk);
            chk($sformatf("run%0d_done_held", i), {done, pass}, {1'b1, tbl[i].pass});
        end

        // Reset asserted mid-run takes effect without a clock edge
        mode = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {dut_in, busy, done, pass, fail_count, ffv, ffv_valid}, 0);
        @(negedge clk); rst_n = 1'b1;
        mode = 0;
        run_main(1'b0, cyc, serr);
        chk("post_reset_cycles", cyc,  24);
        chk("post_reset_seq",    serr, 0);
        chk("post_reset_pass",   {pass, fail_count}, {1'b1, 4'd0});

        // start pokes while busy are ignored; a previous failing run is
        // cleared by the restart from DONE
        mode = 2;
        run_main(1'b0, cyc, serr);
        chk("pre_poke_count", fail_count, 8);
        mode = 0;
        run_main(1'b1, cyc, serr);
        chk("poke_cycles", cyc,  24);
        chk("poke_seq",    serr, 0);
        chk("poke_result", {pass, fail_count, ffv_valid}, {1'b1, 4'd0, 1'b0});
        run_main(1'b0, cyc, serr);
        chk("rerun_cycles", cyc, 24);
        chk("rerun_result", {pass, fail_count}, {1'b1, 4'd0});

        // SETTLE=1 instance: each vector held 2 cycles, done after 16
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("s1_busy", busy1, 1);
        cyc  = -1;
        serr = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dut_in1 !== 3'(((k / 2) > 7) ? 7 : (k / 2))) serr++;
            if (done1 === 1'b1) begin
                cyc = k;
                break;
            end
        end
        chk("s1_cycles", cyc,  16);
        chk("s1_seq",    serr, 0);
        chk("s1_result", {pass1, fail_count1, ffv_valid1, busy1}, {1'b1, 4'd0, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
